sumador_segmentado: RTL

Parametrised, pipelined unsigned adder: the next generation of the two-stage 4-bit summing block. Operands of WIDTH bits are added in SLICE-bit chunks, one chunk per pipeline stage, with the carry rippling between stages. A valid/ready handshake with backpressure carries a tag (idx) alongside each sum. The block sits between the stimulus/probe source and downstream consumers, in the same position as the 4-bit adder it replaces.

---
 rtl/sumador_segmentado.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sumador_segmentado.sv
// sumador_segmentado
//   Pipelined unsigned adder. WIDTH-bit operands are summed SLICE bits per
//   stage, the carry rippling from one stage register to the next, so the
//   result appears STAGES = WIDTH/SLICE edges after acceptance.
//
//   Optional feature macro: SUMADOR_SAT_EN
//     defined   -> sum_out saturates to all ones when the final carry is 1
//                  (carry_out still reports the true carry).
//     undefined -> sum_out is the wrap-around sum modulo 2^WIDTH.
//
//   Ports
//     clk        in   clock, rising edge
//     reset_L    in   asynchronous active-low reset
//     valid_in   in   input transaction present
//     ready_in   out  block accepts input this cycle (combinational)
//     idx        in   IDX_W tag travelling with the operands
//     dataA      in   WIDTH operand A
//     dataB      in   WIDTH operand B
//     valid_out  out  result present on sum_out/carry_out/idx_out
//     ready_out  in   consumer accepts the result this cycle
//     sum_out    out  WIDTH sum
//     carry_out  out  carry out of the MSB
//     idx_out    out  IDX_W tag of the result
//
//   Handshake: a transfer happens at a rising edge where valid and ready are
//   both 1. The whole pipe advances together when adv = ready_out | ~valid_out,
//   and ready_in equals adv, so a stalled output freezes every stage and
//   blocks new input in the same cycle.
//
//   WIDTH must be a multiple of SLICE.
module sumador_segmentado #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic [IDX_W-1:0] idx_out
);

  localparam int STAGES = WIDTH / SLICE;

  // Stage registers. sum_q[k] holds valid sum slices 0..k; opa_q/opb_q[k]
  // carry the operands forward so slices k+1.. are available downstream.
  logic             valid_q [STAGES];
  logic [IDX_W-1:0] idx_q   [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic [WIDTH-1:0] opa_q   [STAGES];
  logic [WIDTH-1:0] opb_q   [STAGES];

  logic             valid_d [STAGES];
  logic [IDX_W-1:0] idx_d   [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic [WIDTH-1:0] opa_d   [STAGES];
  logic [WIDTH-1:0] opb_d   [STAGES];

  // Source of each stage: stage 0 reads the input port, stage k reads k-1.
  logic             src_v   [STAGES];
  logic [IDX_W-1:0] src_idx [STAGES];
  logic             src_c   [STAGES];
  logic [WIDTH-1:0] src_s   [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];

  logic [SLICE:0]   slice_sum;
  logic             adv;

  assign adv      = ready_out | ~valid_out;
  assign ready_in = adv;

  always_comb begin
    slice_sum  = '0;
    src_v[0]   = valid_in;
    src_idx[0] = idx;
    src_c[0]   = 1'b0;
    src_s[0]   = '0;
    src_a[0]   = dataA;
    src_b[0]   = dataB;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]   = valid_q[k-1];
      src_idx[k] = idx_q[k-1];
      src_c[k]   = carry_q[k-1];
      src_s[k]   = sum_q[k-1];
      src_a[k]   = opa_q[k-1];
      src_b[k]   = opb_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, src_a[k][k*SLICE +: SLICE]}
                + {1'b0, src_b[k][k*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, src_c[k]};
      valid_d[k] = src_v[k];
      idx_d[k]   = src_idx[k];
      carry_d[k] = slice_sum[SLICE];
      sum_d[k]   = src_s[k];
      sum_d[k][k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
      opa_d[k]   = src_a[k];
      opb_d[k]   = src_b[k];
    end
`ifdef SUMADOR_SAT_EN
    // Saturate while loading the last stage so the outputs stay registered.
    if (carry_d[STAGES-1]) begin
      sum_d[STAGES-1] = '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        idx_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        opa_q[k]   <= '0;
        opb_q[k]   <= '0;
      end
    end else if (adv) begin
      // Bubbles shift too; their data fields are simply don't-care.
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        idx_q[k]   <= idx_d[k];
        carry_q[k] <= carry_d[k];
        sum_q[k]   <= sum_d[k];
        opa_q[k]   <= opa_d[k];
        opb_q[k]   <= opb_d[k];
      end
    end
  end

  assign valid_out = valid_q[STAGES-1];
  assign sum_out   = sum_q[STAGES-1];
  assign carry_out = carry_q[STAGES-1];
  assign idx_out   = idx_q[STAGES-1];

endmodule
